// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the FFT framing controller: FSM states,
// config-word field layout and the transform-length clamp.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_CFG_SEND = 2'd0,
    ST_RUN      = 2'd1,
    ST_DRAIN    = 2'd2
  } state_e;

  // Config word layout: {scale, fwd, 3'b000, nfft_log2}
  localparam int CFG_NFFT_LSB  = 0;
  localparam int CFG_NFFT_W    = 5;
  localparam int CFG_FWD_BIT   = 8;
  localparam int CFG_SCALE_LSB = 9;

  localparam logic [4:0] NFFT_LOG2_MIN = 5'd3;

  function automatic logic [4:0] clamp_log2(input logic [4:0] req, input logic [4:0] max_log2);
    if (req < NFFT_LOG2_MIN) return NFFT_LOG2_MIN;
    if (req > max_log2) return max_log2;
    return req;
  endfunction

endpackage

// File: rtl/fft_flight_cnt.sv
// Saturating up/down count of frames handed to the FFT core but not yet
// seen leaving it.
module fft_flight_cnt
  import fft_ctrl_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         is_max,
  output logic         is_zero
);

  logic [W-1:0] count_q, count_d;

  assign count   = count_q;
  assign is_max  = (count_q == {W{1'b1}});
  assign is_zero = (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (inc && !dec && !is_max) begin
      count_d = count_q + W'(1);
    end else if (dec && !inc && !is_zero) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Config and framing controller in front of the vendor FFT core.
// Define FFT_FRAME_CTRL_STATUS_EN to add sticky event flags and an output-frame counter.
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int NFFT_MAX_LOG2 = 10,
  parameter int SCALE_W       = 10,
  parameter int FLIGHT_W      = 3,
  parameter int DEF_NFFT_LOG2 = 10,
  parameter int DEF_FWD       = 1,
  parameter int DEF_SCALE     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            cfg_nfft_log2,
  input  logic                  cfg_fwd,
  input  logic [SCALE_W-1:0]    cfg_scale,
  input  logic                  cfg_req,
  output logic                  cfg_busy,
  output logic                  ready,
  input  logic [2*DATA_W-1:0]   s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic [SCALE_W+8:0]    core_cfg_tdata,
  output logic                  core_cfg_tvalid,
  input  logic                  core_cfg_tready,
  output logic [2*DATA_W-1:0]   core_tdata,
  output logic                  core_tvalid,
  input  logic                  core_tready,
  output logic                  core_tlast,
  input  logic                  o_tvalid,
  input  logic                  o_tready,
  input  logic                  o_tlast,
  input  logic                  ev_tlast_unexpected,
  input  logic                  ev_tlast_missing,
  input  logic                  ev_in_halt,
  input  logic                  ev_out_halt,
  output logic                  len_err
`ifdef FFT_FRAME_CTRL_STATUS_EN
  ,
  input  logic                  err_clr,
  output logic [3:0]            err_sticky,
  output logic [31:0]           frame_cnt
`endif
);

  localparam int CFG_W = SCALE_W + 9;
  localparam logic [4:0] MAX_LOG2 = 5'(NFFT_MAX_LOG2);
  localparam logic [NFFT_MAX_LOG2-1:0] CNT_ONES = '1;

  function automatic logic [CFG_W-1:0] build_word(input logic [4:0] log2, input logic fwd,
                                                  input logic [SCALE_W-1:0] scale);
    logic [CFG_W-1:0] w;
    w = '0;
    w[CFG_NFFT_LSB +: CFG_NFFT_W] = log2;
    w[CFG_FWD_BIT]                = fwd;
    w[CFG_SCALE_LSB +: SCALE_W]   = scale;
    return w;
  endfunction

  localparam logic [4:0] DEF_LOG2 = clamp_log2(5'(DEF_NFFT_LOG2), MAX_LOG2);
  localparam logic [CFG_W-1:0] DEF_WORD = build_word(DEF_LOG2, 1'(DEF_FWD), SCALE_W'(DEF_SCALE));

  state_e                     state_q, state_d;
  logic                       cfg_valid_q, cfg_valid_d;
  logic                       busy_q, busy_d;
  logic                       ready_q, ready_d;
  logic                       pending_q, pending_d;
  logic [CFG_W-1:0]           word_q, word_d;
  logic [4:0]                 lat_log2_q, lat_log2_d;
  logic                       lat_fwd_q, lat_fwd_d;
  logic [SCALE_W-1:0]         lat_scale_q, lat_scale_d;
  logic [NFFT_MAX_LOG2-1:0]   in_cnt_q, in_cnt_d;

  logic [4:0]                 act_log2;
  logic [NFFT_MAX_LOG2-1:0]   last_idx;
  logic                       cnt_zero, frame_last, pend_now, gate, in_hs, out_hs_last;
  logic [FLIGHT_W-1:0]        in_flight;
  logic                       flight_max, flight_zero;

  // The word last accepted by the core defines the running frame length.
  assign act_log2    = word_q[CFG_NFFT_LSB +: CFG_NFFT_W];
  assign last_idx    = CNT_ONES >> (MAX_LOG2 - act_log2);
  assign cnt_zero    = (in_cnt_q == '0);
  assign frame_last  = (in_cnt_q == last_idx);
  assign pend_now    = pending_q | cfg_req;
  assign gate        = (state_q == ST_RUN) & ~(pend_now & cnt_zero) & ~(flight_max & cnt_zero) & ~rst;
  assign in_hs       = s_tvalid & core_tready & gate;
  assign out_hs_last = o_tvalid & o_tready & o_tlast;

  assign core_tdata      = s_tdata;
  assign core_tvalid     = s_tvalid & gate;
  assign s_tready        = core_tready & gate;
  assign core_tlast      = frame_last;
  assign len_err         = in_hs & (s_tlast != frame_last);
  assign core_cfg_tdata  = word_q;
  assign core_cfg_tvalid = cfg_valid_q & ~rst;
  assign cfg_busy        = busy_q | rst;
  assign ready           = ready_q & ~rst;

  fft_flight_cnt #(.W(FLIGHT_W)) u_flight (
    .clk     (clk),
    .rst     (rst),
    .inc     (in_hs & frame_last),
    .dec     (out_hs_last),
    .count   (in_flight),
    .is_max  (flight_max),
    .is_zero (flight_zero)
  );

  always_comb begin
    in_cnt_d = in_cnt_q;
    if (in_hs) in_cnt_d = frame_last ? '0 : in_cnt_q + NFFT_MAX_LOG2'(1);
  end

  always_comb begin
    state_d     = state_q;
    cfg_valid_d = cfg_valid_q;
    busy_d      = busy_q;
    ready_d     = ready_q;
    pending_d   = pend_now;
    word_d      = word_q;
    lat_log2_d  = cfg_req ? clamp_log2(cfg_nfft_log2, MAX_LOG2) : lat_log2_q;
    lat_fwd_d   = cfg_req ? cfg_fwd : lat_fwd_q;
    lat_scale_d = cfg_req ? cfg_scale : lat_scale_q;
    unique case (state_q)
      ST_CFG_SEND: begin
        if (!cfg_valid_q) begin
          cfg_valid_d = 1'b1;
          word_d      = build_word(lat_log2_d, lat_fwd_d, lat_scale_d);
          pending_d   = 1'b0;
        end else if (core_cfg_tready) begin
          // A request that arrived while this word was on the bus gets its own send.
          if (pend_now) begin
            word_d    = build_word(lat_log2_d, lat_fwd_d, lat_scale_d);
            pending_d = 1'b0;
          end else begin
            cfg_valid_d = 1'b0;
            busy_d      = 1'b0;
            ready_d     = 1'b1;
            state_d     = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (cfg_req) busy_d = 1'b1;
        if (pend_now && cnt_zero) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (flight_zero) begin
          state_d     = ST_CFG_SEND;
          cfg_valid_d = 1'b1;
          word_d      = build_word(lat_log2_d, lat_fwd_d, lat_scale_d);
          pending_d   = 1'b0;
        end
      end
      default: state_d = ST_CFG_SEND;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CFG_SEND;
      cfg_valid_q <= 1'b0;
      busy_q      <= 1'b1;
      ready_q     <= 1'b0;
      pending_q   <= 1'b0;
      word_q      <= DEF_WORD;
      lat_log2_q  <= DEF_LOG2;
      lat_fwd_q   <= 1'(DEF_FWD);
      lat_scale_q <= SCALE_W'(DEF_SCALE);
      in_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      cfg_valid_q <= cfg_valid_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      pending_q   <= pending_d;
      word_q      <= word_d;
      lat_log2_q  <= lat_log2_d;
      lat_fwd_q   <= lat_fwd_d;
      lat_scale_q <= lat_scale_d;
      in_cnt_q    <= in_cnt_d;
    end
  end

`ifdef FFT_FRAME_CTRL_STATUS_EN
  logic [3:0]  err_sticky_q, err_sticky_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;

  assign err_sticky = err_sticky_q;
  assign frame_cnt  = frame_cnt_q;

  // New events OR in after the clear so a same-cycle event is never lost.
  always_comb begin
    err_sticky_d = (err_clr ? 4'b0000 : err_sticky_q)
                 | {ev_out_halt, ev_in_halt, ev_tlast_missing, ev_tlast_unexpected};
    frame_cnt_d  = frame_cnt_q + {31'd0, out_hs_last};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky_q <= '0;
      frame_cnt_q  <= '0;
    end else begin
      err_sticky_q <= err_sticky_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end
`else
  logic unused_ev;
  assign unused_ev = ^{ev_tlast_unexpected, ev_tlast_missing, ev_in_halt, ev_out_halt};
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: config handshake, framing, len_err,
// in-flight limit, mid-frame reconfiguration and reset mid-frame.
module tb_fft_frame_ctrl;

  localparam int DATA_W  = 16;
  localparam int SCALE_W = 10;
  localparam int CFG_W   = SCALE_W + 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [4:0]          cfg_nfft_log2;
  logic                cfg_fwd;
  logic [SCALE_W-1:0]  cfg_scale;
  logic                cfg_req;
  logic                cfg_busy, ready;
  logic [2*DATA_W-1:0] s_tdata;
  logic                s_tvalid, s_tready, s_tlast;
  logic [CFG_W-1:0]    core_cfg_tdata;
  logic                core_cfg_tvalid, core_cfg_tready;
  logic [2*DATA_W-1:0] core_tdata;
  logic                core_tvalid, core_tready, core_tlast;
  logic                o_tvalid, o_tready, o_tlast;
  logic                ev_tlast_unexpected, ev_tlast_missing, ev_in_halt, ev_out_halt;
  logic                len_err;
`ifdef FFT_FRAME_CTRL_STATUS_EN
  logic                err_clr;
  logic [3:0]          err_sticky;
  logic [31:0]         frame_cnt;
`endif

  fft_frame_ctrl #(.FLIGHT_W(2)) u_dut (
    .clk                 (clk),
    .rst                 (rst),
    .cfg_nfft_log2       (cfg_nfft_log2),
    .cfg_fwd             (cfg_fwd),
    .cfg_scale           (cfg_scale),
    .cfg_req             (cfg_req),
    .cfg_busy            (cfg_busy),
    .ready               (ready),
    .s_tdata             (s_tdata),
    .s_tvalid            (s_tvalid),
    .s_tready            (s_tready),
    .s_tlast             (s_tlast),
    .core_cfg_tdata      (core_cfg_tdata),
    .core_cfg_tvalid     (core_cfg_tvalid),
    .core_cfg_tready     (core_cfg_tready),
    .core_tdata          (core_tdata),
    .core_tvalid         (core_tvalid),
    .core_tready         (core_tready),
    .core_tlast          (core_tlast),
    .o_tvalid            (o_tvalid),
    .o_tready            (o_tready),
    .o_tlast             (o_tlast),
    .ev_tlast_unexpected (ev_tlast_unexpected),
    .ev_tlast_missing    (ev_tlast_missing),
    .ev_in_halt          (ev_in_halt),
    .ev_out_halt         (ev_out_halt),
    .len_err             (len_err)
`ifdef FFT_FRAME_CTRL_STATUS_EN
    ,
    .err_clr             (err_clr),
    .err_sticky          (err_sticky),
    .frame_cnt           (frame_cnt)
`endif
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // One upstream beat: checks the zero-latency pass-through, then lets the edge take it.
  task automatic send_sample(input string tag, input int idx, input logic tl, input logic req,
                             input logic exp_tlast, input logic exp_len_err);
    logic [2*DATA_W-1:0] d;
    d        = {16'(idx), ~16'(idx)};
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = tl;
    cfg_req  = req;
    settle();
    check({tag, "_s_tready"}, s_tready, 1'b1);
    check({tag, "_core_tdata"}, core_tdata, d);
    check({tag, "_core_tlast"}, core_tlast, exp_tlast);
    check({tag, "_len_err"}, len_err, exp_len_err);
    $display("[TB] %s sample %0d data=%08h core_tlast=%0b len_err=%0b", tag, idx, core_tdata,
             core_tlast, len_err);
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    cfg_req  = 1'b0;
  endtask

  task automatic o_pulse();
    o_tvalid = 1'b1;
    o_tready = 1'b1;
    o_tlast  = 1'b1;
    tick();
    o_tvalid = 1'b0;
    o_tready = 1'b0;
    o_tlast  = 1'b0;
    $display("[TB] output tlast snooped");
  endtask

  initial begin
    rst = 1'b1;
    cfg_nfft_log2 = 5'd0; cfg_fwd = 1'b0; cfg_scale = '0; cfg_req = 1'b0;
    s_tdata = '0; s_tvalid = 1'b1; s_tlast = 1'b0;
    core_cfg_tready = 1'b1; core_tready = 1'b1;
    o_tvalid = 1'b0; o_tready = 1'b0; o_tlast = 1'b0;
    ev_tlast_unexpected = 1'b0; ev_tlast_missing = 1'b0; ev_in_halt = 1'b0; ev_out_halt = 1'b0;
`ifdef FFT_FRAME_CTRL_STATUS_EN
    err_clr = 1'b0;
`endif

    // Reset state
    tick(); tick(); tick();
    settle();
    check("rst_cfg_tvalid", core_cfg_tvalid, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_cfg_busy", cfg_busy, 1'b1);
    check("rst_s_tready", s_tready, 1'b0);
    check("rst_core_tvalid", core_tvalid, 1'b0);
    check("rst_len_err", len_err, 1'b0);
    check("rst_cfg_word", core_cfg_tdata, 19'h0010A);
    s_tvalid = 1'b0;
    rst = 1'b0;

    // Default word presented on cycle 1, ready on cycle 2
    tick(); settle();
    check("boot_cfg_tvalid", core_cfg_tvalid, 1'b1);
    check("boot_cfg_word", core_cfg_tdata, 19'h0010A);
    check("boot_ready_early", ready, 1'b0);
    $display("[TB] boot config word %05h", core_cfg_tdata);
    tick(); settle();
    check("boot_ready", ready, 1'b1);
    check("boot_busy", cfg_busy, 1'b0);
    check("boot_cfg_tvalid_done", core_cfg_tvalid, 1'b0);
    check("boot_s_tready", s_tready, 1'b1);

    // Request nfft 2 (clamps to 3): DRAIN next cycle, CFG_SEND the one after
    cfg_nfft_log2 = 5'd2; cfg_fwd = 1'b1; cfg_scale = '0; cfg_req = 1'b1;
    settle();
    check("req_gate", s_tready, 1'b0);
    tick(); cfg_req = 1'b0; settle();
    check("drain_busy", cfg_busy, 1'b1);
    check("drain_cfg_tvalid", core_cfg_tvalid, 1'b0);
    tick(); settle();
    check("n3_cfg_tvalid", core_cfg_tvalid, 1'b1);
    check("n3_cfg_word", core_cfg_tdata, 19'h00103);
    $display("[TB] reconfig word %05h", core_cfg_tdata);
    tick(); settle();
    check("n3_busy", cfg_busy, 1'b0);

    // Two 8-sample frames with correct s_tlast
    for (int i = 0; i < 16; i++) begin
      send_sample("n3", i, (i % 8) == 7, 1'b0, (i % 8) == 7, 1'b0);
    end
    settle();
    check("n3_in_flight", u_dut.in_flight, 2'd2);

    // Early s_tlast on sample 5; generated tlast stays on sample 8
    for (int i = 0; i < 8; i++) begin
      send_sample("lerr", i, (i == 4) || (i == 7), 1'b0, i == 7, i == 4);
    end
    settle();
    check("full_in_flight", u_dut.in_flight, 2'd3);

    // In-flight counter at max: input held at the frame start
    s_tvalid = 1'b1;
    settle();
    check("full_s_tready", s_tready, 1'b0);
    check("full_core_tvalid", core_tvalid, 1'b0);
    tick(); settle();
    check("full_s_tready_hold", s_tready, 1'b0);
    s_tvalid = 1'b0;
    o_tvalid = 1'b1; o_tready = 1'b1; o_tlast = 1'b1;
    settle();
    check("full_s_tready_olast", s_tready, 1'b0);
    tick();
    o_tvalid = 1'b0; o_tready = 1'b0; o_tlast = 1'b0;
    settle();
    check("reopen_s_tready", s_tready, 1'b1);
    check("reopen_in_flight", u_dut.in_flight, 2'd2);
    o_pulse();

    // Mid-frame request for nfft 4, inverse: frame finishes, drain, new word
    cfg_nfft_log2 = 5'd4; cfg_fwd = 1'b0; cfg_scale = 10'h2A5;
    for (int i = 0; i < 8; i++) begin
      send_sample("midreq", i, i == 7, i == 2, i == 7, 1'b0);
    end
    settle();
    check("midreq_gate", s_tready, 1'b0);
    check("midreq_in_flight", u_dut.in_flight, 2'd2);
    tick(); settle();
    check("mdrain_s_tready", s_tready, 1'b0);
    check("mdrain_cfg_tvalid", core_cfg_tvalid, 1'b0);
    check("mdrain_busy", cfg_busy, 1'b1);
    o_pulse(); settle();
    check("mdrain_cfg_tvalid_1", core_cfg_tvalid, 1'b0);
    check("mdrain_s_tready_1", s_tready, 1'b0);
    o_pulse(); settle();
    check("mdrain_cfg_tvalid_2", core_cfg_tvalid, 1'b0);
    tick(); settle();
    check("n4_cfg_tvalid", core_cfg_tvalid, 1'b1);
    check("n4_cfg_word", core_cfg_tdata, 19'h54A04);
    check("n4_s_tready_cfg", s_tready, 1'b0);
    $display("[TB] reconfig word %05h", core_cfg_tdata);
    tick(); settle();
    check("n4_busy", cfg_busy, 1'b0);
    check("n4_s_tready", s_tready, 1'b1);
    for (int i = 0; i < 16; i++) begin
      send_sample("n4", i, i == 15, 1'b0, i == 15, 1'b0);
    end
    settle();
    check("n4_in_flight", u_dut.in_flight, 2'd1);

`ifdef FFT_FRAME_CTRL_STATUS_EN
    check("stat_frame_cnt", frame_cnt, 32'd4);
    ev_in_halt = 1'b1; err_clr = 1'b1;
    tick();
    ev_in_halt = 1'b0; err_clr = 1'b0;
    settle();
    check("stat_set_wins", err_sticky, 4'b0100);
    ev_tlast_unexpected = 1'b1;
    tick();
    ev_tlast_unexpected = 1'b0;
    settle();
    check("stat_sticky_or", err_sticky, 4'b0101);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    settle();
    check("stat_clear", err_sticky, 4'b0000);
    $display("[TB] status sticky=%0h frames=%0d", err_sticky, frame_cnt);
`endif

    // Reset mid-frame abandons everything and resends the default word
    for (int i = 0; i < 3; i++) begin
      send_sample("abort", i, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    tick(); settle();
    check("rst2_busy", cfg_busy, 1'b1);
    check("rst2_ready", ready, 1'b0);
    check("rst2_cfg_tvalid", core_cfg_tvalid, 1'b0);
    check("rst2_s_tready", s_tready, 1'b0);
    check("rst2_in_flight", u_dut.in_flight, 2'd0);
    rst = 1'b0;
    tick(); settle();
    check("rst2_cfg_tvalid_up", core_cfg_tvalid, 1'b1);
    check("rst2_cfg_word", core_cfg_tdata, 19'h0010A);
    tick(); settle();
    check("rst2_ready_up", ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
